regfile_writeback: RTL and testbench
====================================

// Module: regfile_writeback
// PURPOSE
//   Writer side of the 32-entry GPR file: merges ALU results and returning load data into one write per cycle.
//   Drives the register file's write_addr/write_data/write_enable from registered outputs.
//   Buffers load responses in a small FIFO and keeps a per-register busy scoreboard for issue-stage hazard checks.
//   Sits between execute/memory stages and the register file.
// PARAMETERS
//   XLEN         32  data width (matches GPR width)
//   NREG         32  architectural registers; x0 hardwired zero
//   LQ_DEPTH     2   load-response FIFO entries (power of 2, >=2)
//   STARVE_LIMIT 4   cycles a non-empty FIFO head may wait before alu_stall asserts
// PORTS
//   clk            in   1     rising-edge clock
//   rst_n          in   1     reset, synchronous, active-low
//   alu_valid      in   1     ALU result present this cycle (always accepted)
//   alu_rd         in   5     ALU destination register
//   alu_data       in   XLEN  ALU result
//   alu_stall      out  1     registered; upstream must hold alu_valid=0 while high
//   mem_valid      in   1     load response present
//   mem_ready      out  1     block can accept load response
//   mem_rd         in   5     load destination register
//   mem_data       in   XLEN  load data
//   issue_valid    in   1     load issued this cycle; marks issue_rd busy
//   issue_rd       in   5     destination of issued load
//   chk_rs1        in   5     hazard query source 1
//   chk_rs2        in   5     hazard query source 2
//   chk_rd         in   5     hazard query destination (WAW)
//   hazard         out  1     comb: busy[chk_rs1]|busy[chk_rs2]|busy[chk_rd]
//   write_enable   out  1     registered write strobe to GPR file
//   write_addr     out  5     registered GPR write address
//   write_data     out  XLEN  registered GPR write data
// BEHAVIOUR
//   Reset (rst_n=0 at posedge): write_enable=0, write_addr=0, write_data=0, alu_stall=0,
//     FIFO empty, busy[] all 0, starve_cnt=0. mem_ready=0 while rst_n=0.
//   mem_ready = rst_n & (count < LQ_DEPTH); no push-when-full even if popping same cycle.
//   Accept: mem_valid&mem_ready at posedge. mem_rd==0 accepted and discarded (not enqueued).
//   Select each cycle (at most one write):
//     alu_valid & alu_rd!=0 -> ALU source; else FIFO non-empty -> FIFO head (pop); else none.
//     alu_valid & alu_rd==0 -> discarded, does not block FIFO.
//   Output regs load at posedge: write_enable=selected, addr/data=selected values; none -> write_enable=0,
//     addr/data hold previous values.
//   Latency: ALU result at edge N -> write_enable high cycle N..N+1 (visible after edge N).
//     Load accepted edge N into empty FIFO, no ALU conflict -> written at edge N+1.
//   Scoreboard: issue_valid & issue_rd!=0 sets busy[issue_rd]; FIFO pop to rd clears busy[rd].
//     Set and clear of same rd on same edge -> set wins. busy[0] always 0. ALU writes never change busy.
//     Issue stage must honour hazard; second issue to a busy rd is illegal (assertion in bench).
//   Starvation: starve_cnt++ each cycle FIFO non-empty and no pop; cleared on pop or FIFO empty.
//     alu_stall registered = (next starve_cnt >= STARVE_LIMIT). While alu_stall=1 FIFO wins; alu_valid=1 then
//     is a protocol violation (bench asserts). Pop clears starve_cnt and alu_stall next edge.
//   FIFO: circular, wrap-around pointers over LQ_DEPTH; count 0..LQ_DEPTH; simultaneous push+pop keeps count.
//   Reset mid-operation: FIFO contents and busy bits dropped; no write issued on the reset edge.
// TESTING
//   ALU only: alu_valid=1 rd=5 data=0xDEADBEEF -> next cycle write_enable=1 addr=5 data=0xDEADBEEF.
//   x0 drop: alu rd=0 data=0x1234 with FIFO head rd=7 -> FIFO head written, no write to 0.
//   Conflict: ALU rd=3 and FIFO head rd=9 same cycle -> rd3 written, rd9 next cycle, busy[9] clears then.
//   Full: two loads accepted, ALU busy every cycle -> mem_ready=0, after 4 waits alu_stall=1, head popped.
//   Scoreboard: issue rd=12 -> hazard=1 for chk_rs1=12; set+clear same edge rd=12 -> busy stays 1.
//   Reset mid-op: rst_n=0 with 2 FIFO entries, busy[4]=1 -> all outputs 0, hazard=0, no writes after.

Source files
------------

// File: rtl/regfile_writeback.sv
// GPR write-port arbiter: merges ALU results and buffered load responses into one
// registered write per cycle, and tracks per-register busy bits for hazard checks.
module regfile_writeback #(
    parameter int XLEN         = 32,
    parameter int NREG         = 32,
    parameter int LQ_DEPTH     = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_stall,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_data,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    input  logic [4:0]      chk_rs1,
    input  logic [4:0]      chk_rs2,
    input  logic [4:0]      chk_rd,
    output logic            hazard,
    output logic            write_enable,
    output logic [4:0]      write_addr,
    output logic [XLEN-1:0] write_data
);

    localparam int PW = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
    localparam int CW = $clog2(LQ_DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]      lq_rd_q   [LQ_DEPTH];
    logic [XLEN-1:0] lq_data_q [LQ_DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic [NREG-1:0] busy_q, busy_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic            alu_stall_q, alu_stall_d;
    logic            write_enable_q, write_enable_d;
    logic [4:0]      write_addr_q, write_addr_d;
    logic [XLEN-1:0] write_data_q, write_data_d;

    logic lq_empty, push, pop, alu_sel;
    logic [4:0] head_rd;

    assign lq_empty  = (count_q == '0);
    assign mem_ready = rst_n && (count_q < CW'(LQ_DEPTH));
    // Writes to x0 are accepted from the memory side but never occupy a FIFO slot.
    assign push      = mem_valid && mem_ready && (mem_rd != '0);
    assign alu_sel   = alu_valid && (alu_rd != '0) && !alu_stall_q;
    assign pop       = !alu_sel && !lq_empty;
    assign head_rd   = lq_rd_q[rd_ptr_q];

    assign hazard       = busy_q[chk_rs1] | busy_q[chk_rs2] | busy_q[chk_rd];
    assign alu_stall    = alu_stall_q;
    assign write_enable = write_enable_q;
    assign write_addr   = write_addr_q;
    assign write_data   = write_data_q;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        write_enable_d = alu_sel || pop;
        write_addr_d   = write_addr_q;
        write_data_d   = write_data_q;
        if (alu_sel) begin
            write_addr_d = alu_rd;
            write_data_d = alu_data;
        end else if (pop) begin
            write_addr_d = head_rd;
            write_data_d = lq_data_q[rd_ptr_q];
        end

        count_d = count_q;
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push) count_d = count_q - CW'(1);

        // Clear first so a same-edge re-issue of the popped register keeps it busy.
        busy_d = busy_q;
        if (pop)                               busy_d[head_rd]  = 1'b0;
        if (issue_valid && (issue_rd != '0))   busy_d[issue_rd] = 1'b1;
        busy_d[0] = 1'b0;

        starve_d = starve_q;
        if (lq_empty || pop)                    starve_d = '0;
        else if (starve_q < SW'(STARVE_LIMIT))  starve_d = starve_q + SW'(1);
        alu_stall_d = (starve_d >= SW'(STARVE_LIMIT));
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            busy_q         <= '0;
            starve_q       <= '0;
            alu_stall_q    <= 1'b0;
            write_enable_q <= 1'b0;
            write_addr_q   <= '0;
            write_data_q   <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q        <= count_d;
            busy_q         <= busy_d;
            starve_q       <= starve_d;
            alu_stall_q    <= alu_stall_d;
            write_enable_q <= write_enable_d;
            write_addr_q   <= write_addr_d;
            write_data_q   <= write_data_d;
        end
    end

    // NOTE: FIFO storage is not reset; count_q alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            lq_rd_q[wr_ptr_q]   <= mem_rd;
            lq_data_q[wr_ptr_q] <= mem_data;
        end
    end

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: expected writes go into a queue as stimulus is
// issued; a negedge monitor pops and compares whenever write_enable is high.
module tb_regfile_writeback;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        bit          is_load;
    } wr_t;

    logic        clk, rst_n;
    logic        alu_valid, mem_valid, issue_valid;
    logic [4:0]  alu_rd, mem_rd, issue_rd, chk_rs1, chk_rs2, chk_rd;
    logic [31:0] alu_data, mem_data;
    logic        alu_stall, mem_ready, hazard, write_enable;
    logic [4:0]  write_addr;
    logic [31:0] write_data;

    int  errors = 0;
    int  checks = 0;
    wr_t exp_q[$];
    bit  [31:0] tb_busy;
    bit  prev_iv;
    logic [4:0] prev_ird;
    bit  reissue_ok;

    regfile_writeback #(.XLEN(32), .NREG(32), .LQ_DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd), .hazard(hazard),
        .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_alu(input logic [4:0] rd, input logic [31:0] data);
        alu_valid = 1'b1;
        alu_rd    = rd;
        alu_data  = data;
    endtask

    task automatic drive_mem(input logic [4:0] rd, input logic [31:0] data);
        mem_valid = 1'b1;
        mem_rd    = rd;
        mem_data  = data;
    endtask

    task automatic expect_wr(input logic [4:0] rd, input logic [31:0] data, input bit is_load);
        wr_t e;
        e.rd = rd;
        e.data = data;
        e.is_load = is_load;
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic [4:0] rd);
        issue_valid = 1'b1;
        issue_rd    = rd;
        tick();
        issue_valid = 1'b0;
    endtask

    // Monitor plus protocol guards (ALU idle while stalled, no re-issue to a busy rd).
    always @(negedge clk) begin
        if (write_enable === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%0d data=%h, expected no write", write_addr, write_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (write_addr !== e.rd || write_data !== e.data) begin
                    errors++;
                    $display("FAIL write: got addr=%0d data=%h expected addr=%0d data=%h",
                             write_addr, write_data, e.rd, e.data);
                end
                if (e.is_load && !(prev_iv && prev_ird == e.rd)) tb_busy[e.rd] = 1'b0;
            end
        end
        if (!rst_n) begin
            tb_busy = '0;
            prev_iv = 1'b0;
        end else begin
            if (alu_valid) begin
                checks++;
                if (alu_stall !== 1'b0) begin
                    errors++;
                    $display("FAIL alu_during_stall: got alu_valid=1 with alu_stall=%b expected alu_stall=0", alu_stall);
                end
            end
            if (issue_valid && issue_rd != '0) begin
                checks++;
                if (tb_busy[issue_rd] && !reissue_ok) begin
                    errors++;
                    $display("FAIL reissue_busy: got issue to busy rd=%0d expected idle rd", issue_rd);
                end
                tb_busy[issue_rd] = 1'b1;
            end
            prev_iv  = issue_valid && (issue_rd != '0);
            prev_ird = issue_rd;
        end
    end

    initial begin
        rst_n = 1'b0;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        mem_valid = 0; mem_rd = 0; mem_data = 0;
        issue_valid = 0; issue_rd = 0;
        chk_rs1 = 0; chk_rs2 = 0; chk_rd = 0;
        reissue_ok = 0; tb_busy = '0; prev_iv = 0; prev_ird = 0;

        // Reset state
        tick(); tick();
        check("rst_we",    32'(write_enable), 0);
        check("rst_addr",  32'(write_addr), 0);
        check("rst_data",  write_data, 0);
        check("rst_stall", 32'(alu_stall), 0);
        check("rst_mem_ready", 32'(mem_ready), 0);
        check("rst_hazard", 32'(hazard), 0);
        rst_n = 1'b1;
        #1 check("mem_ready_after_rst", 32'(mem_ready), 1);

        // ALU only, then hold of addr/data with write_enable low
        drive_alu(5, 32'hDEAD_BEEF);
        expect_wr(5, 32'hDEAD_BEEF, 0);
        tick();
        alu_valid = 0;
        tick();
        check("idle_we",   32'(write_enable), 0);
        check("hold_addr", 32'(write_addr), 5);
        check("hold_data", write_data, 32'hDEAD_BEEF);

        // x0 ALU result dropped, FIFO head rd=7 written instead
        issue(7);
        chk_rs1 = 7;
        #1 check("haz7_set", 32'(hazard), 1);
        drive_mem(7, 32'h0000_0077);
        tick();
        mem_valid = 0;
        drive_alu(0, 32'h0000_1234);
        expect_wr(7, 32'h0000_0077, 1);
        check("haz7_before_pop", 32'(hazard), 1);
        tick();
        alu_valid = 0;
        check("haz7_cleared", 32'(hazard), 0);

        // ALU rd=3 vs FIFO head rd=9 in the same cycle
        issue(9);
        chk_rs1 = 9;
        drive_mem(9, 32'h0000_0099);
        tick();
        mem_valid = 0;
        drive_alu(3, 32'h0000_0033);
        expect_wr(3, 32'h0000_0033, 0);
        expect_wr(9, 32'h0000_0099, 1);
        tick();
        alu_valid = 0;
        check("haz9_held", 32'(hazard), 1);
        tick();
        check("haz9_cleared", 32'(hazard), 0);

        // Set and clear of rd=12 on the same edge: set wins
        issue(12);
        chk_rs1 = 12;
        #1 check("haz12_set", 32'(hazard), 1);
        drive_mem(12, 32'h0000_C0C0);
        tick();
        mem_valid = 0;
        issue_valid = 1; issue_rd = 12; reissue_ok = 1;
        expect_wr(12, 32'h0000_C0C0, 1);
        tick();
        issue_valid = 0; reissue_ok = 0;
        check("haz12_setwins", 32'(hazard), 1);
        chk_rs1 = 0; chk_rd = 12;
        #1 check("haz12_via_rd", 32'(hazard), 1);
        chk_rd = 0; chk_rs2 = 12;
        #1 check("haz12_via_rs2", 32'(hazard), 1);
        chk_rs2 = 0;
        #1 check("haz_x0", 32'(hazard), 0);

        // FIFO full under continuous ALU traffic -> starvation stall
        issue(20);
        issue(21);
        drive_mem(20, 32'h0000_00A0); drive_alu(1, 32'h0000_0101); expect_wr(1, 32'h0000_0101, 0);
        tick();
        drive_mem(21, 32'h0000_00A1); drive_alu(2, 32'h0000_0102); expect_wr(2, 32'h0000_0102, 0);
        tick();
        check("full_mem_ready", 32'(mem_ready), 0);
        check("stall_wait1", 32'(alu_stall), 0);
        drive_mem(22, 32'h0000_0BAD); drive_alu(3, 32'h0000_0103); expect_wr(3, 32'h0000_0103, 0);
        tick();
        drive_alu(4, 32'h0000_0104); expect_wr(4, 32'h0000_0104, 0);
        tick();
        check("stall_wait3", 32'(alu_stall), 0);
        drive_alu(5, 32'h0000_0105); expect_wr(5, 32'h0000_0105, 0);
        expect_wr(20, 32'h0000_00A0, 1);
        expect_wr(21, 32'h0000_00A1, 1);
        tick();
        check("stall_set", 32'(alu_stall), 1);
        check("stall_mem_ready", 32'(mem_ready), 0);
        alu_valid = 0; mem_valid = 0;
        chk_rs1 = 20; chk_rs2 = 21;
        tick();
        check("stall_cleared", 32'(alu_stall), 0);
        check("pop_mem_ready", 32'(mem_ready), 1);
        check("haz21_held", 32'(hazard), 1);
        tick();
        check("haz20_21_cleared", 32'(hazard), 0);
        chk_rs1 = 0; chk_rs2 = 0;

        // Reset mid-operation with two queued loads and busy[4]
        issue(4);
        issue(25);
        drive_mem(4, 32'h0000_0044); drive_alu(6, 32'h0000_0066); expect_wr(6, 32'h0000_0066, 0);
        tick();
        drive_mem(25, 32'h0000_0055); drive_alu(7, 32'h0000_0077); expect_wr(7, 32'h0000_0077, 0);
        tick();
        mem_valid = 0;
        rst_n = 0;
        drive_alu(8, 32'h0000_0088);
        chk_rs1 = 4; chk_rs2 = 25; chk_rd = 12;
        #1 check("midrst_mem_ready", 32'(mem_ready), 0);
        tick();
        alu_valid = 0;
        check("midrst_we",     32'(write_enable), 0);
        check("midrst_addr",   32'(write_addr), 0);
        check("midrst_data",   write_data, 0);
        check("midrst_stall",  32'(alu_stall), 0);
        check("midrst_hazard", 32'(hazard), 0);
        rst_n = 1;
        repeat (4) tick();
        check("post_rst_we", 32'(write_enable), 0);
        check("queue_drained", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
